// File: rtl/sit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sit_pkg
//  Brief    : Shared SiT definitions: S-box, bit permutation, F-function,
//             round count, round-key selection and engine state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package sit_pkg;

    localparam int SIT_ROUNDS = 5;

    // Nibble n of the table holds S(n).
    localparam logic [63:0] SIT_SBOX = 64'h2174_8FE3_DA09_B65C;
    // Nibble i of the table holds the source bit index for output bit i.
    localparam logic [63:0] SIT_PERM = 64'hFB73_EA62_D951_C840;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } sit_state_e;

    function automatic logic [15:0] sit_f(input logic [15:0] x);
        logic [15:0] s;
        logic [15:0] y;
        for (int n = 0; n < 4; n++) begin
            s[4*n +: 4] = SIT_SBOX[4*int'(x[4*n +: 4]) +: 4];
        end
        for (int i = 0; i < 16; i++) begin
            y[i] = s[SIT_PERM[4*i +: 4]];
        end
        return y;
    endfunction

    function automatic logic [15:0] sit_round_key(input logic [79:0] kexp,
                                                  input logic [2:0]  r);
        logic [15:0] k;
        case (r)
            3'd1:    k = kexp[79:64];
            3'd2:    k = kexp[63:48];
            3'd3:    k = kexp[47:32];
            3'd4:    k = kexp[31:16];
            default: k = kexp[15:0];
        endcase
        return k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sit_encrypt_iter_if.sv
`default_nettype none
// ============================================================================
//  Module   : sit_encrypt_iter_if
//  Brief    : Plaintext/key input stream and ciphertext output stream.
//  Revision : 1.0 - initial release
// ============================================================================
interface sit_encrypt_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] key;
    logic [63:0] plaintext;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] cphtext;

    modport slave (
        input  in_valid, key, plaintext, out_ready,
        output in_ready, out_valid, cphtext
    );

    modport master (
        output in_valid, key, plaintext, out_ready,
        input  in_ready, out_valid, cphtext
    );
endinterface
`default_nettype wire

// File: rtl/sit_decrypt.sv
`default_nettype none
// ============================================================================
//  Module   : sit_decrypt
//  Brief    : Combinational SiT decryption datapath; undoes the five rounds
//             of sit_encrypt_iter in reverse key order.
//  Revision : 1.1 - F-function taken from sit_pkg
// ============================================================================
module sit_decrypt
    import sit_pkg::*;
(
    input  wire logic [63:0] key_i,
    input  wire logic [63:0] cphtext_i,
    output logic      [63:0] plaintext_o
);

    logic [79:0] kexp;
    logic [63:0] stg [SIT_ROUNDS+1];

    sit_key_expand u_kexp (
        .key_i  (key_i),
        .kexp_o (kexp)
    );

    assign stg[0] = cphtext_i;

    // Stage i inverts round (5 - i), whose key sits at kexp[16*i +: 16].
    for (genvar i = 0; i < SIT_ROUNDS; i++) begin : g_inv
        logic [15:0] k, a, b, c, d;
        assign k = kexp[16*i +: 16];
        if (i == 0) begin : g_last
            assign {a, b, c, d} = stg[i];
        end else begin : g_mid
            assign {b, a, d, c} = stg[i];
        end
        assign stg[i+1] = {~(a ^ k), sit_f(d) ^ c, sit_f(a) ^ b, ~(d ^ k)};
    end

    assign plaintext_o = stg[SIT_ROUNDS];

endmodule
`default_nettype wire

// File: rtl/sit_key_expand.sv
`default_nettype none
// ============================================================================
//  Module   : sit_key_expand
//  Brief    : Combinational 64-bit to 80-bit SiT key expansion (five 16-bit
//             round keys, the fifth being the XOR of the first four).
//  Revision : 1.0 - initial release
// ============================================================================
module sit_key_expand
    import sit_pkg::*;
(
    input  wire logic [63:0] key_i,
    output logic      [79:0] kexp_o
);

    logic [15:0] ka [4];

    // Each key block gathers the same nibble position from all four key words.
    for (genvar j = 0; j < 4; j++) begin : g_kblk
        logic [15:0] kb;
        assign kb    = {key_i[63-4*j -: 4], key_i[47-4*j -: 4],
                        key_i[31-4*j -: 4], key_i[15-4*j -: 4]};
        assign ka[j] = sit_f(kb);
    end

    assign kexp_o = {ka[0], ka[1], ka[2], ka[3], ka[0] ^ ka[1] ^ ka[2] ^ ka[3]};

endmodule
`default_nettype wire

// File: rtl/sit_encrypt_iter.sv
`default_nettype none
// ============================================================================
//  Module   : sit_encrypt_iter
//  Brief    : Iterative SiT encryption engine, one round per clock, with a
//             valid/ready stream on each side. Define SIT_BLK_CNT_EN to add
//             the saturating blk_count completed-block counter.
//  Revision : 1.0 - initial release
// ============================================================================
module sit_encrypt_iter
    import sit_pkg::*;
#(
    parameter int ROUNDS = SIT_ROUNDS
) (
    input  wire logic         clk,
    input  wire logic         rst,
    sit_encrypt_iter_if.slave bus
`ifdef SIT_BLK_CNT_EN
    ,
    output logic [15:0]       blk_count
`endif
);

    if (ROUNDS != SIT_ROUNDS) begin : g_rounds_chk
        $error("sit_encrypt_iter: only ROUNDS=5 is supported");
    end

    sit_state_e  state_q, state_d;
    logic [63:0] blk_q, blk_d;
    logic [79:0] kexp_q, kexp_d;
    logic [2:0]  rnd_q, rnd_d;
    logic [79:0] kexp_w;

    sit_key_expand u_kexp (
        .key_i  (bus.key),
        .kexp_o (kexp_w)
    );

    logic [15:0] rk, a, b, c, d;
    logic        last_rnd;
    logic [63:0] round_out;

    assign rk        = sit_round_key(kexp_q, rnd_q);
    assign a         = ~(blk_q[63:48] ^ rk);
    assign d         = ~(blk_q[15:0]  ^ rk);
    assign b         = sit_f(a) ^ blk_q[31:16];
    assign c         = sit_f(d) ^ blk_q[47:32];
    assign last_rnd  = (rnd_q == 3'(ROUNDS));
    // The final round skips the word swap so the decryptor can mirror it.
    assign round_out = last_rnd ? {a, b, c, d} : {b, a, d, c};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            blk_q   <= '0;
            kexp_q  <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            kexp_q  <= kexp_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        kexp_d  = kexp_q;
        rnd_d   = rnd_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = ROUND;
                    blk_d   = bus.plaintext;
                    kexp_d  = kexp_w;
                    rnd_d   = 3'd1;
                end
            end
            ROUND: begin
                blk_d = round_out;
                if (last_rnd) begin
                    state_d = DONE;
                end else begin
                    rnd_d = rnd_q + 3'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.cphtext   = bus.out_valid ? blk_q : 64'h0;

`ifdef SIT_BLK_CNT_EN
    logic [15:0] blk_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt_q <= '0;
        end else if (bus.out_valid && bus.out_ready && (blk_cnt_q != 16'hFFFF)) begin
            blk_cnt_q <= blk_cnt_q + 16'd1;
        end
    end

    assign blk_count = blk_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sit_encrypt_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sit_encrypt_iter
//  Brief    : Directed self-checking bench for sit_encrypt_iter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sit_encrypt_iter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sit_encrypt_iter_if bus ();

`ifdef SIT_BLK_CNT_EN
    logic [15:0] blk_count;
`endif

    sit_encrypt_iter dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef SIT_BLK_CNT_EN
        ,
        .blk_count (blk_count)
`endif
    );

    logic [63:0] dec_key, dec_ct, dec_pt;

    sit_decrypt u_dec (
        .key_i       (dec_key),
        .cphtext_i   (dec_ct),
        .plaintext_o (dec_pt)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: S-box followed by a 4x4 bit transpose.
    int SB [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

    function automatic logic [15:0] m_f(input logic [15:0] x);
        logic [15:0] s, y;
        for (int n = 0; n < 4; n++) s[4*n +: 4] = 4'(SB[x[4*n +: 4]]);
        for (int r = 0; r < 4; r++)
            for (int q = 0; q < 4; q++) y[4*r+q] = s[4*q+r];
        return y;
    endfunction

    function automatic logic [79:0] m_kexp(input logic [63:0] key);
        logic [15:0] ka [4];
        for (int j = 0; j < 4; j++)
            ka[j] = m_f({key[4*(15-j) +: 4], key[4*(11-j) +: 4],
                         key[4*(7-j) +: 4],  key[4*(3-j) +: 4]});
        return {ka[0], ka[1], ka[2], ka[3], ka[0] ^ ka[1] ^ ka[2] ^ ka[3]};
    endfunction

    function automatic logic [63:0] m_enc(input logic [63:0] key, input logic [63:0] pt);
        logic [79:0] kx;
        logic [63:0] s;
        logic [15:0] k, a, b, c, d;
        kx = m_kexp(key);
        s  = pt;
        for (int r = 1; r <= 5; r++) begin
            k = kx[80-16*r +: 16];
            a = ~(s[63:48] ^ k);
            d = ~(s[15:0] ^ k);
            b = m_f(a) ^ s[31:16];
            c = m_f(d) ^ s[47:32];
            s = (r == 5) ? {a, b, c, d} : {b, a, d, c};
        end
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with the engine idle; returns at a negedge, idle again.
    task automatic run_block(input string tag, input logic [63:0] key, input logic [63:0] pt,
                             input int delay, input logic [63:0] exp);
        int          n;
        int          leaks;
        logic [63:0] held;
        bus.key       = key;
        bus.plaintext = pt;
        bus.in_valid  = 1'b1;
        bus.out_ready = (delay == 0);
        chk({tag, " in_ready"}, 64'(bus.in_ready), 64'h1);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.key       = ~key;
        bus.plaintext = ~pt;
        n     = 0;
        leaks = 0;
        while (!bus.out_valid && n < 20) begin
            if (bus.cphtext !== 64'h0) leaks++;
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'd5);
        chk({tag, " gated"}, 64'(leaks), 64'd0);
        chk({tag, " cphtext"}, bus.cphtext, exp);
        dec_key = key;
        dec_ct  = bus.cphtext;
        #1;
        chk({tag, " roundtrip"}, dec_pt, pt);
        held = bus.cphtext;
        for (int k = 0; k < delay; k++) begin
            bus.in_valid = 1'b1;
            @(negedge clk);
            chk({tag, " hold ct"}, bus.cphtext, held);
            chk({tag, " hold rdy"}, {bus.out_valid, bus.in_ready}, 64'h2);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk({tag, " post vld"}, 64'(bus.out_valid), 64'h0);
        chk({tag, " post rdy"}, 64'(bus.in_ready), 64'h1);
        chk({tag, " post ct"}, bus.cphtext, 64'h0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    typedef struct {
        logic [63:0] key;
        logic [63:0] pt;
        int          delay;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{64'h0, 64'h0, 0, 64'h0};
        vecs[1] = '{64'h0F1E2D3C4B5A6978, 64'h0123456789ABCDEF, 0, 64'h0};
        vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 10, 64'h0};
        vecs[3] = '{64'h0123456789ABCDEF, 64'h0, 2, 64'h0};
        vecs[4] = '{64'h0, 64'h8000000000000001, 0, 64'h0};
        vecs[5] = '{64'hDEADBEEFCAFEF00D, 64'h5A5A5A5AA5A5A5A5, 1, 64'h0};
        foreach (vecs[i]) vecs[i].exp = m_enc(vecs[i].key, vecs[i].pt);

        dec_key       = '0;
        dec_ct        = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.key       = '0;
        bus.plaintext = '0;
        rst           = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset in_ready", 64'(bus.in_ready), 64'h1);
        chk("reset out_valid", 64'(bus.out_valid), 64'h0);
        chk("reset cphtext", bus.cphtext, 64'h0);
`ifdef SIT_BLK_CNT_EN
        chk("reset blk_count", 64'(blk_count), 64'h0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_block($sformatf("vec%0d", i), vecs[i].key, vecs[i].pt, vecs[i].delay, vecs[i].exp);
        end

        // Reset landing on the third round discards the block.
        bus.key       = vecs[5].key;
        bus.plaintext = vecs[5].pt;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst in_ready", 64'(bus.in_ready), 64'h1);
        chk("midrst out_valid", 64'(bus.out_valid), 64'h0);
        chk("midrst cphtext", bus.cphtext, 64'h0);
`ifdef SIT_BLK_CNT_EN
        chk("midrst blk_count", 64'(blk_count), 64'h0);
`endif
        run_block("after_rst", vecs[1].key, vecs[1].pt, 0, vecs[1].exp);

`ifdef SIT_BLK_CNT_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_block($sformatf("cnt%0d", i), vecs[i].key, vecs[i].pt, 0, vecs[i].exp);
        end
        chk("blk_count 3", 64'(blk_count), 64'd3);
        force dut.blk_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.blk_cnt_q;
        run_block("cnt_sat", vecs[3].key, vecs[3].pt, 0, vecs[3].exp);
        chk("blk_count sat", 64'(blk_count), 64'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
